// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC arctangent sequencer.
package cordic_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam int ANGLE_W = 16;
  localparam logic signed [ANGLE_W-1:0] DEG_180 = 16'sd180;
  // Cycles cordic_start must be held high before the core raises finished.
  localparam int CORDIC_LAT = 19;

endpackage

// File: rtl/cordic_prerot.sv
// Combinational pre-rotation: folds a vector into the right half-plane and
// selects the +/-180 degree correction to add back after the core.
module cordic_prerot
  import cordic_pkg::*;
#(
  parameter int PRESHIFT = 2
) (
  input  logic signed [31:0]        x,
  input  logic signed [31:0]        y,
  output logic signed [31:0]        px,
  output logic signed [31:0]        py,
  output logic signed [ANGLE_W-1:0] corr,
  output logic                      is_zero
);

  localparam logic signed [31:0] S32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] S32_MAX = 32'sh7FFF_FFFF;

  logic signed [31:0] nx;
  logic signed [31:0] ny;

  // -2^31 has no positive counterpart, so it clamps to 2^31-1.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v);
    return (v == S32_MIN) ? S32_MAX : -v;
  endfunction

  always_comb begin
    nx   = x;
    ny   = y;
    corr = '0;
    if (x < 0) begin
      nx   = sat_neg(x);
      ny   = sat_neg(y);
      corr = (y < 0) ? -DEG_180 : DEG_180;
    end
  end

  assign px      = nx >>> PRESHIFT;
  assign py      = ny >>> PRESHIFT;
  assign is_zero = (x == 0) && (y == 0);

endmodule

// File: rtl/cordic_atan_seq.sv
// Sequencer around the pipelined CORDIC atan core: pre-rotate, run the core,
// apply the quadrant correction and hand out a full-range angle in degrees.
module cordic_atan_seq
  import cordic_pkg::*;
#(
  parameter int TIMEOUT  = 32,
  parameter int PRESHIFT = 2
) (
  input  logic                      clk_50M,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [31:0]        in_x,
  input  logic signed [31:0]        in_y,
  output logic signed [31:0]        cordic_x,
  output logic signed [31:0]        cordic_y,
  output logic                      cordic_start,
  input  logic                      cordic_finished,
  input  logic [31:0]               cordic_atan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ANGLE_W-1:0] out_angle,
  output logic                      out_err_zero,
  output logic                      out_err_timeout
);

  // Handshakes: a transfer happens on a rising clk_50M edge where valid and
  // ready are both high; valid never waits on ready, and once raised valid
  // and its payload stay stable until that transfer.

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  state_t                     state, state_n;
  logic                       in_ready_q;
  logic signed [ANGLE_W-1:0]  corr_q;
  logic [CNT_W-1:0]           run_cnt;
  logic signed [31:0]         pr_x, pr_y;
  logic signed [ANGLE_W-1:0]  pr_corr;
  logic                       pr_zero;
  logic                       accept;
  logic                       timed_out;
  logic                       unused_atan_hi;

  cordic_prerot #(.PRESHIFT(PRESHIFT)) u_prerot (
    .x       (in_x),
    .y       (in_y),
    .px      (pr_x),
    .py      (pr_y),
    .corr    (pr_corr),
    .is_zero (pr_zero)
  );

  assign accept         = (state == S_IDLE) && in_valid && in_ready_q;
  assign timed_out      = (run_cnt == CNT_W'(TIMEOUT));
  assign unused_atan_hi = ^cordic_atan[31:16];

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = pr_zero ? S_OUT : S_RUN;
      S_RUN: begin
        if (cordic_finished)  state_n = S_WAIT;
        else if (timed_out)   state_n = S_OUT;
      end
      S_WAIT: state_n = S_OUT;
      S_OUT:  if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      in_ready_q      <= 1'b0;
      cordic_x        <= '0;
      cordic_y        <= '0;
      corr_q          <= '0;
      run_cnt         <= '0;
      out_angle       <= '0;
      out_err_zero    <= 1'b0;
      out_err_timeout <= 1'b0;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n == S_IDLE);
      case (state)
        S_IDLE: if (accept) begin
          cordic_x <= pr_x;
          cordic_y <= pr_y;
          corr_q   <= pr_corr;
          run_cnt  <= CNT_W'(1);
          if (pr_zero) begin
            out_angle    <= '0;
            out_err_zero <= 1'b1;
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (!cordic_finished && timed_out) begin
            out_angle       <= '0;
            out_err_timeout <= 1'b1;
          end
        end
        // The core's atan register is valid only in this cycle.
        S_WAIT: out_angle <= $signed(cordic_atan[ANGLE_W-1:0]) + corr_q;
        S_OUT: if (out_ready) begin
          out_err_zero    <= 1'b0;
          out_err_timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign cordic_start = (state == S_RUN);
  assign out_valid    = (state == S_OUT);

endmodule

// File: tb/tb_cordic_atan_seq.sv
// Bench for cordic_atan_seq with a behavioural model of the CORDIC core.
module tb_cordic_atan_seq;
  import cordic_pkg::*;

  localparam int TIMEOUT  = 32;
  localparam int PRESHIFT = 2;
  localparam real PI = 3.14159265358979;

  // ---------------- clock / reset ----------------
  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;
  always #10 clk_50M = ~clk_50M;

  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_x = '0;
  logic signed [31:0] in_y = '0;
  logic signed [31:0] cordic_x, cordic_y;
  logic               cordic_start;
  logic               cordic_finished;
  logic [31:0]        cordic_atan;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_angle;
  logic               out_err_zero, out_err_timeout;

  cordic_atan_seq #(.TIMEOUT(TIMEOUT), .PRESHIFT(PRESHIFT)) dut (
    .clk_50M         (clk_50M),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_x            (in_x),
    .in_y            (in_y),
    .cordic_x        (cordic_x),
    .cordic_y        (cordic_y),
    .cordic_start    (cordic_start),
    .cordic_finished (cordic_finished),
    .cordic_atan     (cordic_atan),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_angle       (out_angle),
    .out_err_zero    (out_err_zero),
    .out_err_timeout (out_err_timeout)
  );

  // ---------------- core model ----------------
  logic       core_dead = 1'b0;
  logic       late_fin  = 1'b0;
  logic [7:0] core_cnt;
  logic [31:0] core_atan_q;

  function automatic logic [15:0] core_deg(input logic signed [31:0] x, input logic signed [31:0] y);
    real r;
    r = $atan2($itor(y), $itor(x)) * 180.0 / PI;
    return 16'($rtoi(r));
  endfunction

  always @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      core_cnt    <= '0;
      core_atan_q <= '0;
    end else if (cordic_start) begin
      core_cnt <= core_cnt + 8'd1;
      if (core_cnt == 8'(CORDIC_LAT - 1))
        core_atan_q <= {16'hA5A5, core_deg(cordic_x, cordic_y)};
    end else begin
      core_cnt <= '0;
    end
  end

  assign cordic_finished = late_fin |
    (!core_dead && cordic_start && core_cnt == 8'(CORDIC_LAT - 1));
  assign cordic_atan = core_atan_q;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Scoreboard: pop one expected record per output transfer.
  always @(negedge clk_50M) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 1'b0, int'(out_angle), 0);
      end else begin
        logic [33:0] e;
        logic signed [15:0] lo, hi;
        e  = exp_q.pop_front();
        lo = e[33:18];
        hi = e[17:2];
        check("sb_angle", (out_angle >= lo) && (out_angle <= hi), int'(out_angle), int'(lo));
        check("sb_err_zero", out_err_zero == e[1], int'(out_err_zero), int'(e[1]));
        check("sb_err_timeout", out_err_timeout == e[0], int'(out_err_timeout), int'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic signed [31:0] x, input logic signed [31:0] y,
                      input logic signed [15:0] lo, input logic signed [15:0] hi,
                      input bit ez, input bit et);
    int guard;
    guard = 0;
    @(negedge clk_50M);
    while (!in_ready && guard < 200) begin
      @(negedge clk_50M);
      guard++;
    end
    if (guard >= 200) check("in_ready_wait", 1'b0, 0, 1);
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    exp_q.push_back({lo, hi, ez, et});
    @(posedge clk_50M);
    #1 in_valid = 1'b0;
  endtask

  // Called just after the input handshake edge; counts cycles to out_valid.
  task automatic wait_out(output int lat, output int starts,
                          input logic signed [31:0] ex_cx, input logic signed [31:0] ex_cy);
    lat = 0;
    starts = 0;
    do begin
      @(negedge clk_50M);
      lat++;
      if (cordic_start) begin
        if (starts == 0) begin
          check("cordic_x", cordic_x == ex_cx, int'(cordic_x), int'(ex_cx));
          check("cordic_y", cordic_y == ex_cy, int'(cordic_y), int'(ex_cy));
        end
        starts++;
      end
    end while (!out_valid && lat < 100);
    if (!out_valid) check("out_valid_wait", 1'b0, lat, 100);
  endtask

  function automatic logic signed [31:0] pre_op(input logic signed [31:0] v, input bit neg);
    logic signed [31:0] n;
    n = v;
    if (neg) n = (v == 32'sh8000_0000) ? 32'sh7FFF_FFFF : -v;
    return n >>> PRESHIFT;
  endfunction

  typedef struct {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [15:0] lo;
    logic signed [15:0] hi;
    bit                 ez;
    logic signed [31:0] cx;
    logic signed [31:0] cy;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, starts;
    logic signed [15:0] a0;

    vecs[0]  = '{32'sd1000,  32'sd1000,  16'sd44,   16'sd45,   1'b0, 32'sd250, 32'sd250};
    vecs[1]  = '{-32'sd1000, 32'sd1000,  16'sd134,  16'sd135,  1'b0, 32'sd250, -32'sd250};
    vecs[2]  = '{-32'sd1000, -32'sd1000, -16'sd135, -16'sd134, 1'b0, 32'sd250, 32'sd250};
    vecs[3]  = '{32'sd0,     -32'sd500,  -16'sd90,  -16'sd89,  1'b0, 32'sd0,   -32'sd125};
    vecs[4]  = '{32'sd0,     32'sd0,     16'sd0,    16'sd0,    1'b1, 32'sd0,   32'sd0};
    vecs[5]  = '{32'sh8000_0000, 32'sd5, 16'sd179,  16'sd180,  1'b0, 32'sd536870911, -32'sd2};
    vecs[6]  = '{32'sd0,     32'sd700,   16'sd89,   16'sd90,   1'b0, 32'sd0,   32'sd175};
    vecs[7]  = '{32'sd5000,  32'sd0,     16'sd0,    16'sd0,    1'b0, 32'sd1250, 32'sd0};
    vecs[8]  = '{-32'sd5000, 32'sd0,     16'sd179,  16'sd180,  1'b0, 32'sd1250, 32'sd0};
    vecs[9]  = '{32'sh8000_0000, 32'sh8000_0000, -16'sd135, -16'sd134, 1'b0, 32'sd536870911, 32'sd536870911};
    vecs[10] = '{32'sh7FFF_FFFF, 32'sh8000_0000, -16'sd45, -16'sd44, 1'b0, 32'sd536870911, -32'sd536870912};
    vecs[11] = '{32'sd1000,  -32'sd1,    -16'sd1,   16'sd0,    1'b0, 32'sd250, -32'sd1};

    // Reset state
    #5;
    check("rst_in_ready", in_ready == 1'b0, int'(in_ready), 0);
    check("rst_start", cordic_start == 1'b0, int'(cordic_start), 0);
    check("rst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    check("rst_angle", out_angle == 16'sd0, int'(out_angle), 0);
    check("rst_cordic_x", cordic_x == 32'sd0, int'(cordic_x), 0);
    check("rst_errs", {out_err_zero, out_err_timeout} == 2'b00, int'({out_err_zero, out_err_timeout}), 0);
    repeat (2) @(negedge clk_50M);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].x, vecs[i].y, vecs[i].lo, vecs[i].hi, vecs[i].ez, 1'b0);
      wait_out(lat, starts, vecs[i].cx, vecs[i].cy);
      check($sformatf("latency_v%0d", i), lat == (vecs[i].ez ? 1 : CORDIC_LAT + 2), lat,
            vecs[i].ez ? 1 : CORDIC_LAT + 2);
      check($sformatf("start_cycles_v%0d", i), starts == (vecs[i].ez ? 0 : CORDIC_LAT), starts,
            vecs[i].ez ? 0 : CORDIC_LAT);
    end

    // Random vectors against a floating-point atan2 reference
    for (int i = 0; i < 6; i++) begin
      logic signed [31:0] rx, ry;
      int t, lo_i, hi_i;
      rx = 32'($urandom_range(1000, 20000));
      ry = 32'($urandom_range(1000, 20000));
      if ($urandom_range(0, 1) == 1) rx = -rx;
      if ($urandom_range(0, 1) == 1) ry = -ry;
      t = $rtoi($atan2($itor(ry), $itor(rx)) * 180.0 / PI);
      lo_i = (t - 2 < -180) ? -180 : t - 2;
      hi_i = (t + 2 > 180) ? 180 : t + 2;
      send(rx, ry, 16'(lo_i), 16'(hi_i), 1'b0, 1'b0);
      wait_out(lat, starts, pre_op(rx, rx < 0), pre_op(ry, rx < 0));
      check("latency_rand", lat == CORDIC_LAT + 2, lat, CORDIC_LAT + 2);
    end

    // Core never finishes: timeout after TIMEOUT start cycles
    core_dead = 1'b1;
    send(32'sd100, 32'sd200, 16'sd0, 16'sd0, 1'b0, 1'b1);
    wait_out(lat, starts, 32'sd25, 32'sd50);
    check("timeout_start_cycles", starts == TIMEOUT, starts, TIMEOUT);
    check("timeout_latency", lat == TIMEOUT + 1, lat, TIMEOUT + 1);
    core_dead = 1'b0;

    // Stray finished while idle is ignored
    @(negedge clk_50M);
    @(negedge clk_50M);
    late_fin = 1'b1;
    @(negedge clk_50M);
    late_fin = 1'b0;
    check("late_fin_idle_ready", in_ready == 1'b1, int'(in_ready), 1);
    check("late_fin_idle_valid", out_valid == 1'b0, int'(out_valid), 0);

    // Backpressure: result held for 10 cycles with out_ready low
    out_ready = 1'b0;
    send(32'sd1000, 32'sd1000, 16'sd44, 16'sd45, 1'b0, 1'b0);
    wait_out(lat, starts, 32'sd250, 32'sd250);
    a0 = out_angle;
    check("hold_latency", lat == CORDIC_LAT + 2, lat, CORDIC_LAT + 2);
    for (int k = 0; k < 10; k++) begin
      late_fin = (k == 3);
      @(negedge clk_50M);
      check("hold_valid", out_valid == 1'b1, int'(out_valid), 1);
      check("hold_angle", out_angle == a0, int'(out_angle), int'(a0));
      check("hold_in_ready", in_ready == 1'b0, int'(in_ready), 0);
    end
    late_fin = 1'b0;
    @(posedge clk_50M);
    #1 out_ready = 1'b1;
    @(negedge clk_50M);
    @(negedge clk_50M);
    check("release_in_ready", in_ready == 1'b1, int'(in_ready), 1);
    check("release_valid", out_valid == 1'b0, int'(out_valid), 0);

    // Asynchronous reset in cycle 8 of RUN
    send(32'sd1000, 32'sd1000, 16'sd44, 16'sd45, 1'b0, 1'b0);
    repeat (8) @(negedge clk_50M);
    check("pre_reset_start", cordic_start == 1'b1, int'(cordic_start), 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrun_rst_start", cordic_start == 1'b0, int'(cordic_start), 0);
    check("midrun_rst_in_ready", in_ready == 1'b0, int'(in_ready), 0);
    check("midrun_rst_cordic_x", cordic_x == 32'sd0, int'(cordic_x), 0);
    check("midrun_rst_cordic_y", cordic_y == 32'sd0, int'(cordic_y), 0);
    check("midrun_rst_valid", out_valid == 1'b0, int'(out_valid), 0);
    @(negedge clk_50M);
    rst_n = 1'b1;
    send(-32'sd1000, 32'sd1000, 16'sd134, 16'sd135, 1'b0, 1'b0);
    wait_out(lat, starts, 32'sd250, -32'sd250);
    check("post_reset_latency", lat == CORDIC_LAT + 2, lat, CORDIC_LAT + 2);

    repeat (3) @(negedge clk_50M);
    check("sb_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
